sim_jtag_vec_driver: RTL

- Vector-mode JTAG master for the simulation top-level.
- The host-side bridge hands it complete TMS/TDI bit vectors of up to MAX_BITS bits per command, instead of ticking the socket once per TCK edge.
- The block shifts each vector out at a parametrised TCK rate, captures TDO into a response vector, and drives tck/tms/tdi/trst_n of the DUT top directly.
- It replaces per-bit pacing (fixed tick delay) with programmable TCK division, TRST pulses and ready/valid flow control on both sides.

---
 rtl/sim_jtag_vec_driver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sim_jtag_vec_driver.sv
// Vector-mode JTAG master: shifts whole TMS/TDI vectors at a divided TCK rate,
// captures TDO on the TCK rising edge and returns it with ready/valid.
`timescale 1ns/1ps
module sim_jtag_vec_driver #(
    parameter int MAX_BITS    = 32,
    parameter int TCK_DIV     = 2,
    parameter int TRST_CYCLES = 4,
    localparam int LW         = $clog2(MAX_BITS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_trst_i,
    input  logic [LW-1:0]       cmd_len_i,
    input  logic [MAX_BITS-1:0] cmd_tms_i,
    input  logic [MAX_BITS-1:0] cmd_tdi_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [MAX_BITS-1:0] rsp_tdo_o,
    output logic [LW-1:0]       rsp_len_o,
    output logic                rsp_err_o,
    output logic                jtag_tck_o,
    output logic                jtag_tms_o,
    output logic                jtag_tdi_o,
    output logic                jtag_trstn_o,
    input  logic                jtag_tdo_i,
    output logic                busy_o
);
    localparam int IW   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int CMAX = (TCK_DIV > TRST_CYCLES) ? TCK_DIV : TRST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_TRST, S_LOW, S_HIGH, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q, idx_nx;
    logic [LW-1:0]       len_q, len_eff;
    logic                err_q;
    logic [MAX_BITS-1:0] tms_q, tdi_q, tdo_q;
    logic                accept, div_last, trst_last, bit_last;

    assign cmd_ready_o  = (state_q == S_IDLE) & rst_ni;
    assign busy_o       = (state_q != S_IDLE);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_tdo_o    = tdo_q;
    assign rsp_len_o    = len_q;
    assign rsp_err_o    = err_q;

    always_comb begin
        accept    = cmd_valid_i & cmd_ready_o;
        len_eff   = (cmd_len_i > LW'(MAX_BITS)) ? LW'(MAX_BITS) : cmd_len_i;
        div_last  = (cnt_q == CW'(TCK_DIV - 1));
        trst_last = (cnt_q == CW'(TRST_CYCLES - 1));
        bit_last  = ((LW'(idx_q) + LW'(1)) == len_q);
        idx_nx    = idx_q + IW'(1);
        state_d   = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (cmd_trst_i)          state_d = S_TRST;
                else if (len_eff == '0)  state_d = S_RESP;
                else                     state_d = S_LOW;
            end
            S_TRST: if (trst_last) state_d = S_RESP;
            S_LOW:  if (div_last)  state_d = S_HIGH;
            S_HIGH: if (div_last)  state_d = bit_last ? S_RESP : S_LOW;
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            tms_q        <= '0;
            tdi_q        <= '0;
            tdo_q        <= '0;
            jtag_tck_o   <= 1'b0;
            jtag_tms_o   <= 1'b1;
            jtag_tdi_o   <= 1'b0;
            jtag_trstn_o <= 1'b1;
        end else begin
            state_q <= state_d;
            // Phase counter restarts on every state change, so each state owns its own timing.
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
            case (state_q)
                S_IDLE: if (accept) begin
                    tms_q <= cmd_tms_i;
                    tdi_q <= cmd_tdi_i;
                    tdo_q <= '0;
                    idx_q <= '0;
                    len_q <= cmd_trst_i ? '0 : len_eff;
                    err_q <= ~cmd_trst_i & (cmd_len_i > LW'(MAX_BITS));
                    if (cmd_trst_i) begin
                        jtag_trstn_o <= 1'b0;
                    end else if (len_eff != '0) begin
                        jtag_tms_o <= cmd_tms_i[0];
                        jtag_tdi_o <= cmd_tdi_i[0];
                    end
                end
                S_TRST: if (trst_last) jtag_trstn_o <= 1'b1;
                S_LOW: if (div_last) begin
                    jtag_tck_o   <= 1'b1;
                    tdo_q[idx_q] <= jtag_tdo_i;
                end
                S_HIGH: if (div_last) begin
                    jtag_tck_o <= 1'b0;
                    if (!bit_last) begin
                        idx_q      <= idx_nx;
                        jtag_tms_o <= tms_q[idx_nx];
                        jtag_tdi_o <= tdi_q[idx_nx];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
